sign_divide: RTL and testbench
==============================

# sign_divide

Sequential sign-magnitude divider, the inverse counterpart of the `sign_multiply` block. It takes an 8-bit-magnitude signed dividend (the same format as a `sign_multiply` product) and a 5-bit sign-magnitude divisor. It returns a signed quotient and remainder using restoring division, one quotient bit per clock. It sits beside `sign_multiply` in the arithmetic lab datapath and uses a start/busy/done handshake.

## Interface
- `DW`, 8: dividend and quotient magnitude width; also the iteration count.
- `VW`, 4: divisor and remainder magnitude width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when the FSM is in IDLE or DONE.
- `a_sign` input 1: dividend sign (1 = negative).
- `a_mag` input DW: dividend magnitude.
- `b` input VW+1: divisor in sign-magnitude; `b[VW]` is the sign, `b[VW-1:0]` is the magnitude.
- `q` output DW: quotient magnitude.
- `q_sign` output 1: quotient sign.
- `r` output VW: remainder magnitude.
- `r_sign` output 1: remainder sign.
- `busy` output 1: division in progress.
- `done` output 1: one-cycle pulse; results valid.
- `div_zero` output 1: the last operation had a zero divisor magnitude.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: shifts and subtracts.
  - DONE: lasts one cycle, then goes to IDLE.
- Transitions:
  - In IDLE or DONE with `start`=1: capture `a_sign`, `a_mag`, `b`, go to RUN, and load the iteration counter with DW-1.
  - `start` while in RUN is ignored; the operands are not re-captured.
- Each RUN cycle (restoring division):
  - Partial remainder is VW+1 bits: `p = {p[VW-1:0], dividend MSB}`.
  - The dividend shifts left by 1.
  - If `p >= divisor magnitude`: `p = p - divisor` and the new quotient LSB is 1; otherwise the LSB is 0.
  - After DW iterations, go to DONE.
- Results:
  - `q` is the accumulated quotient; `r` is `p[VW-1:0]`.
  - `q_sign = a_sign ^ b[VW]`.
  - `r_sign = a_sign` (truncating division: the remainder takes the dividend's sign).
- Divide by zero (divisor magnitude = 0; this includes "-0" = `5'b10000`):
  - Detected on the capture edge; RUN lasts one cycle and no iterations are performed.
  - Results: `q` = all ones (255), `r` = 0, `q_sign` = 0, `r_sign` = 0, `div_zero` = 1.
- `div_zero` is cleared on the next capture edge.
- `q`, `r`, the signs and `div_zero` are registered. They hold their values from DONE until the next result, and do not change during RUN.
- Reset values: `q`=0, `q_sign`=0, `r`=0, `r_sign`=0, `busy`=0, `done`=0, `div_zero`=0, FSM in IDLE, counter 0.
- Reset during RUN aborts the operation on that edge: no `done` pulse, outputs go to their reset values, and the next `start` proceeds normally.

## Timing
- Edge E0: `start` is sampled high in IDLE or DONE; after E0, `busy`=1.
- Edges E1 to E(DW) perform the iterations. After E(DW):
  - `busy`=0, `done`=1, and the results are valid.
  - Latency is DW cycles from capture to `done` (8 by default).
- After E(DW+1): `done`=0. If `start` was high in DONE, this is also a new capture edge and `busy`=1 (back-to-back operations, no idle cycle).
- Divide by zero: `busy` is high for one cycle; `done`=1 after E1.
- `busy` and `done` are never high together.

## Configuration
- Macro: `SIGN_DIVIDE_ZERO_NORM_EN`.
- Defined: a zero magnitude forces its sign to 0, so `q`=0 gives `q_sign`=0 and `r`=0 gives `r_sign`=0. No negative zero is ever output.
- Undefined: the signs are the raw values (`q_sign = a_sign ^ b[VW]`, `r_sign = a_sign`) even when the magnitude is 0. The divide-by-zero result signs stay 0 in both builds.

## Test plan
- `a_sign`=0, `a_mag`=100, `b`=`5'b10111` (-7), `start` pulse → `done` 8 cycles after capture; `q`=14, `q_sign`=1, `r`=2, `r_sign`=0; `busy` high for exactly 8 cycles.
- `a_sign`=1, `a_mag`=255, `b`=`5'b01111` (+15) → `q`=17, `q_sign`=1, `r`=0. With the macro, `r_sign`=0; without it, `r_sign`=1.
- `a_mag`=50, `b`=`5'b10000` → `done` 1 cycle after capture; `div_zero`=1, `q`=255, `r`=0, both signs 0. A following 9 ÷ 3 gives `div_zero`=0, `q`=3, `r`=0.
- Start 20 ÷ +3, then re-pulse `start` with different operands 3 cycles later → the second request is ignored; `q`=6, `r`=2. Hold `start` high through DONE → a second operation begins with no idle cycle.
- Assert `rst` for one cycle during the 4th RUN cycle → no `done` pulse, all outputs 0 the next cycle; a following 200 ÷ -9 gives `q`=22, `q_sign`=1, `r`=2, `r_sign`=0.

Source files
------------

// File: rtl/sign_divide.sv
// Sequential sign-magnitude restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional build macro SIGN_DIVIDE_ZERO_NORM_EN forces the sign of a zero magnitude result to 0.
module sign_divide #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          a_sign,
  input  logic [DW-1:0] a_mag,
  input  logic [VW:0]   b,
  output logic [DW-1:0] q,
  output logic          q_sign,
  output logic [VW-1:0] r,
  output logic          r_sign,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic [1:0]    o_dbg_state
);

  // Handshake: start is sampled only in IDLE or DONE; busy marks RUN; done is a
  // one-cycle pulse with results valid, and never overlaps busy.
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_quo;
  logic [VW:0]   r_p;
  logic [VW-1:0] r_dvs;
  logic          r_a_sign;
  logic          r_b_sign;
  logic          r_zero;
  logic [DW-1:0] r_q;
  logic          r_q_sign;
  logic [VW-1:0] r_r;
  logic          r_r_sign;
  logic          r_busy;
  logic          r_done;
  logic          r_div_zero;

  logic [VW:0]   w_p_shift;
  logic          w_ge;
  logic [VW:0]   w_p_next;
  logic [DW-1:0] w_quo_next;
  logic          w_q_sign;
  logic          w_r_sign;
  logic          w_capture;

  assign w_p_shift  = {r_p[VW-1:0], r_dvd[DW-1]};
  assign w_ge       = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_next   = w_ge ? (w_p_shift - {1'b0, r_dvs}) : w_p_shift;
  assign w_quo_next = {r_quo[DW-2:0], w_ge};
  assign w_capture  = start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef SIGN_DIVIDE_ZERO_NORM_EN
  assign w_q_sign = (w_quo_next != '0) ? (r_a_sign ^ r_b_sign) : 1'b0;
  assign w_r_sign = (w_p_next[VW-1:0] != '0) ? r_a_sign : 1'b0;
`else
  assign w_q_sign = r_a_sign ^ r_b_sign;
  assign w_r_sign = r_a_sign;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_quo      <= '0;
      r_p        <= '0;
      r_dvs      <= '0;
      r_a_sign   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_zero     <= 1'b0;
      r_q        <= '0;
      r_q_sign   <= 1'b0;
      r_r        <= '0;
      r_r_sign   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_capture) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_cnt      <= CW'(DW - 1);
            r_dvd      <= a_mag;
            r_quo      <= '0;
            r_p        <= '0;
            r_dvs      <= b[VW-1:0];
            r_a_sign   <= a_sign;
            r_b_sign   <= b[VW];
            r_zero     <= (b[VW-1:0] == '0);
            r_div_zero <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_zero) begin
            // Zero divisor (either sign) skips the iterations entirely.
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_q        <= '1;
            r_q_sign   <= 1'b0;
            r_r        <= '0;
            r_r_sign   <= 1'b0;
            r_div_zero <= 1'b1;
          end else begin
            r_p   <= w_p_next;
            r_dvd <= {r_dvd[DW-2:0], 1'b0};
            r_quo <= w_quo_next;
            if (r_cnt == '0) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_q      <= w_quo_next;
              r_q_sign <= w_q_sign;
              r_r      <= w_p_next[VW-1:0];
              r_r_sign <= w_r_sign;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign q           = r_q;
  assign q_sign      = r_q_sign;
  assign r           = r_r;
  assign r_sign      = r_r_sign;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_zero    = r_div_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sign_divide.sv
// Directed-vector bench for sign_divide with hand-computed quotients, remainders and timing.
module tb_sign_divide;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a_sign;
  logic [7:0] a_mag;
  logic [4:0] b;
  logic [7:0] q;
  logic       q_sign;
  logic [3:0] r;
  logic       r_sign;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sign_divide #(.DW(8), .VW(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_sign     (a_sign),
    .a_mag      (a_mag),
    .b          (b),
    .q          (q),
    .q_sign     (q_sign),
    .r          (r),
    .r_sign     (r_sign),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic start_op(input logic s, input logic [7:0] m, input logic [4:0] d);
    a_sign = s;
    a_mag  = m;
    b      = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Counts edges after capture until done; busy_cnt includes the cycle after capture.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
    end
    if (!done) check("done_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] eq, input logic eqs,
                              input logic [3:0] er, input logic ers, input logic edz);
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_qs"}, 32'(q_sign), 32'(eqs));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_rs"}, 32'(r_sign), 32'(ers));
    check({tag, "_dz"}, 32'(div_zero), 32'(edz));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  logic exp_rs_neg0;
  int   cyc, bcnt, done_seen;

  initial begin
`ifdef SIGN_DIVIDE_ZERO_NORM_EN
    exp_rs_neg0 = 1'b0;
`else
    exp_rs_neg0 = 1'b1;
`endif
    rst = 1'b1; start = 1'b0; a_sign = 1'b0; a_mag = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 100 / -7 = -14 rem 2
    start_op(1'b0, 8'd100, 5'b10111);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_state_run", 32'(dbg_state), 32'd1);
    wait_done(cyc, bcnt);
    check("t1_latency", 32'(cyc), 32'd8);
    check("t1_busy_cycles", 32'(bcnt), 32'd8);
    check_result("t1", 8'd14, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_q_hold", 32'(q), 32'd14);

    // -255 / +15 = -17 rem 0; remainder sign depends on zero normalisation
    start_op(1'b1, 8'd255, 5'b01111);
    wait_done(cyc, bcnt);
    check_result("t2", 8'd17, 1'b1, 4'd0, exp_rs_neg0, 1'b0);

    // Divide by -0, then a normal 9 / 3
    start_op(1'b0, 8'd50, 5'b10000);
    wait_done(cyc, bcnt);
    check("t3_latency", 32'(cyc), 32'd1);
    check("t3_busy_cycles", 32'(bcnt), 32'd1);
    check_result("t3", 8'd255, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    start_op(1'b0, 8'd9, 5'b00011);
    check("t3b_dz_clear", 32'(div_zero), 32'd0);
    wait_done(cyc, bcnt);
    check_result("t3b", 8'd3, 1'b0, 4'd0, 1'b0, 1'b0);

    // 20 / +3 with an ignored re-start during RUN
    tick();
    start_op(1'b0, 8'd20, 5'b00011);
    tick(); tick();
    start_op(1'b1, 8'd77, 5'b00101);
    wait_done(cyc, bcnt);
    check("t4_latency", 32'(cyc + 3), 32'd8);
    check_result("t4", 8'd6, 1'b0, 4'd2, 1'b0, 1'b0);

    // Back-to-back: start held high through DONE
    tick();
    a_sign = 1'b0; a_mag = 8'd9; b = 5'b00011; start = 1'b1;
    tick();
    a_sign = 1'b0; a_mag = 8'd200; b = 5'b11001;
    wait_done(cyc, bcnt);
    check_result("t5a", 8'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    check("t5_b2b_busy", 32'(busy), 32'd1);
    check("t5_b2b_done", 32'(done), 32'd0);
    wait_done(cyc, bcnt);
    check("t5b_latency", 32'(cyc), 32'd8);
    check_result("t5b", 8'd22, 1'b1, 4'd2, 1'b0, 1'b0);

    // Reset during the 4th RUN cycle
    tick();
    start_op(1'b1, 8'd100, 5'b00111);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_q", 32'(q), 32'd0);
    check("t6_rst_qs", 32'(q_sign), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    start_op(1'b0, 8'd200, 5'b11001);
    wait_done(cyc, bcnt);
    check("t6_latency", 32'(cyc), 32'd8);
    check_result("t6", 8'd22, 1'b1, 4'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
